// File: rtl/ins_encoder_pkg.sv
// Shared definitions for the RV32I re-encoder.
// Holds operand widths, decoded-op numbering, opcode/funct3/funct7 constants,
// and the encoding-format classes used by the tuple-to-word core.
package ins_encoder_pkg;

    localparam int OPE_WIDTH           = 6;
    localparam int EX_REG_NUMBER_WIDTH = 6;
    localparam int DATA_WIDTH          = 32;
    localparam int INS_WIDTH           = 32;

    // Register index meaning "no operand"
    localparam logic [EX_REG_NUMBER_WIDTH-1:0] REG_NUMBER = 6'd32;

    // Decoded operation numbering (EMPTY_INS marks "no instruction")
    typedef enum logic [OPE_WIDTH-1:0] {
        OP_EMPTY_INS = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } ins_op_e;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    // funct3 values
    localparam logic [2:0] F3_JALR = 3'd0;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2;
    localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB   = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;
    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;

    // funct7 values
    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Instruction layout classes
    typedef enum logic [2:0] {
        FMT_NONE, FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_SH, FMT_R
    } fmt_e;

    // Register field: low 5 bits, "no operand" encodes as x0
    function automatic logic [4:0] reg_field(input logic [EX_REG_NUMBER_WIDTH-1:0] r);
        return (r == REG_NUMBER) ? 5'd0 : r[4:0];
    endfunction

endpackage

// File: rtl/ins_encoder_enc_core.sv
// Pure combinational decoded-tuple to RV32I word encoder.
// Optional ENC_RANGE_CHECK_EN: flags immediates that do not fit their field
// and missing required register operands as errors instead of truncating.
module ins_encoder_enc_core
    import ins_encoder_pkg::*;
(
    input  logic [OPE_WIDTH-1:0]           ins_type,
    input  logic [EX_REG_NUMBER_WIDTH-1:0] ins_rd,
    input  logic [EX_REG_NUMBER_WIDTH-1:0] ins_rs1,
    input  logic [EX_REG_NUMBER_WIDTH-1:0] ins_rs2,
    input  logic [DATA_WIDTH-1:0]          ins_imm,
    output logic [INS_WIDTH-1:0]           code,
    output logic                           err
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    fmt_e        fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] raw;
    logic        range_bad;

    assign rd  = reg_field(ins_rd);
    assign rs1 = reg_field(ins_rs1);
    assign rs2 = reg_field(ins_rs2);
    assign imm = ins_imm;

    // Classify the op: opcode, function fields and layout
    always_comb begin
        opc = 7'd0;
        f3  = 3'd0;
        f7  = F7_ZERO;
        fmt = FMT_NONE;
        case (ins_type)
            OP_LUI:   begin opc = OPC_LUI;    fmt = FMT_U; end
            OP_AUIPC: begin opc = OPC_AUIPC;  fmt = FMT_U; end
            OP_JAL:   begin opc = OPC_JAL;    fmt = FMT_J; end
            OP_JALR:  begin opc = OPC_JALR;   f3 = F3_JALR; fmt = FMT_I; end
            OP_BEQ:   begin opc = OPC_BRANCH; f3 = F3_BEQ;  fmt = FMT_B; end
            OP_BNE:   begin opc = OPC_BRANCH; f3 = F3_BNE;  fmt = FMT_B; end
            OP_BLT:   begin opc = OPC_BRANCH; f3 = F3_BLT;  fmt = FMT_B; end
            OP_BGE:   begin opc = OPC_BRANCH; f3 = F3_BGE;  fmt = FMT_B; end
            OP_BLTU:  begin opc = OPC_BRANCH; f3 = F3_BLTU; fmt = FMT_B; end
            OP_BGEU:  begin opc = OPC_BRANCH; f3 = F3_BGEU; fmt = FMT_B; end
            OP_LB:    begin opc = OPC_LOAD;   f3 = F3_LB;   fmt = FMT_I; end
            OP_LH:    begin opc = OPC_LOAD;   f3 = F3_LH;   fmt = FMT_I; end
            OP_LW:    begin opc = OPC_LOAD;   f3 = F3_LW;   fmt = FMT_I; end
            OP_LBU:   begin opc = OPC_LOAD;   f3 = F3_LBU;  fmt = FMT_I; end
            OP_LHU:   begin opc = OPC_LOAD;   f3 = F3_LHU;  fmt = FMT_I; end
            OP_SB:    begin opc = OPC_STORE;  f3 = F3_SB;   fmt = FMT_S; end
            OP_SH:    begin opc = OPC_STORE;  f3 = F3_SH;   fmt = FMT_S; end
            OP_SW:    begin opc = OPC_STORE;  f3 = F3_SW;   fmt = FMT_S; end
            OP_ADDI:  begin opc = OPC_OP_IMM; f3 = F3_ADD;  fmt = FMT_I; end
            OP_SLTI:  begin opc = OPC_OP_IMM; f3 = F3_SLT;  fmt = FMT_I; end
            OP_SLTIU: begin opc = OPC_OP_IMM; f3 = F3_SLTU; fmt = FMT_I; end
            OP_XORI:  begin opc = OPC_OP_IMM; f3 = F3_XOR;  fmt = FMT_I; end
            OP_ORI:   begin opc = OPC_OP_IMM; f3 = F3_OR;   fmt = FMT_I; end
            OP_ANDI:  begin opc = OPC_OP_IMM; f3 = F3_AND;  fmt = FMT_I; end
            OP_SLLI:  begin opc = OPC_OP_IMM; f3 = F3_SLL;  fmt = FMT_SH; end
            OP_SRLI:  begin opc = OPC_OP_IMM; f3 = F3_SR;   fmt = FMT_SH; end
            OP_SRAI:  begin opc = OPC_OP_IMM; f3 = F3_SR;   f7 = F7_ALT; fmt = FMT_SH; end
            OP_ADD:   begin opc = OPC_OP;     f3 = F3_ADD;  fmt = FMT_R; end
            OP_SUB:   begin opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; fmt = FMT_R; end
            OP_SLL:   begin opc = OPC_OP;     f3 = F3_SLL;  fmt = FMT_R; end
            OP_SLT:   begin opc = OPC_OP;     f3 = F3_SLT;  fmt = FMT_R; end
            OP_SLTU:  begin opc = OPC_OP;     f3 = F3_SLTU; fmt = FMT_R; end
            OP_XOR:   begin opc = OPC_OP;     f3 = F3_XOR;  fmt = FMT_R; end
            OP_SRL:   begin opc = OPC_OP;     f3 = F3_SR;   fmt = FMT_R; end
            OP_SRA:   begin opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; fmt = FMT_R; end
            OP_OR:    begin opc = OPC_OP;     f3 = F3_OR;   fmt = FMT_R; end
            OP_AND:   begin opc = OPC_OP;     f3 = F3_AND;  fmt = FMT_R; end
            default:  fmt = FMT_NONE;
        endcase
    end

    // Assemble the word according to its layout
    always_comb begin
        raw = 32'd0;
        case (fmt)
            FMT_U:   raw = {imm[31:12], rd, opc};
            FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            FMT_I:   raw = {imm[11:0], rs1, f3, rd, opc};
            FMT_S:   raw = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_SH:  raw = {f7, imm[4:0], rs1, f3, rd, opc};
            FMT_R:   raw = {f7, rs2, rs1, f3, rd, opc};
            default: raw = 32'd0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic imm_bad, need_rd, need_rs1, need_rs2;

    // Reject immediates that would not survive truncation, and absent operands
    always_comb begin
        imm_bad  = 1'b0;
        need_rd  = 1'b0;
        need_rs1 = 1'b0;
        need_rs2 = 1'b0;
        case (fmt)
            FMT_U:  begin imm_bad = |imm[11:0]; need_rd = 1'b1; end
            FMT_J:  begin imm_bad = imm[0] || (imm[31:20] != {12{imm[20]}}); need_rd = 1'b1; end
            FMT_I:  begin imm_bad = (imm[31:11] != {21{imm[11]}}); need_rd = 1'b1; need_rs1 = 1'b1; end
            FMT_S:  begin imm_bad = (imm[31:11] != {21{imm[11]}}); need_rs1 = 1'b1; need_rs2 = 1'b1; end
            FMT_B:  begin imm_bad = imm[0] || (imm[31:12] != {20{imm[12]}}); need_rs1 = 1'b1; need_rs2 = 1'b1; end
            FMT_SH: begin imm_bad = |imm[31:5]; need_rd = 1'b1; need_rs1 = 1'b1; end
            FMT_R:  begin need_rd = 1'b1; need_rs1 = 1'b1; need_rs2 = 1'b1; end
            default: imm_bad = 1'b0;
        endcase
        range_bad = imm_bad
                 || (need_rd  && (ins_rd  == REG_NUMBER))
                 || (need_rs1 && (ins_rs1 == REG_NUMBER))
                 || (need_rs2 && (ins_rs2 == REG_NUMBER));
    end
`else
    assign range_bad = 1'b0;
`endif

    assign err  = (fmt == FMT_NONE) || range_bad;
    assign code = err ? 32'd0 : raw;

endmodule

// File: rtl/ins_encoder.sv
// RV32I re-encoder: valid/ready wrapper with a 2-entry output FIFO around
// the combinational encoding core. Outputs come straight from flops.
// Optional ENC_RANGE_CHECK_EN (in the core) enables immediate/operand checks.
module ins_encoder
    import ins_encoder_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OPE_WIDTH-1:0]           ins_type,
    input  logic [EX_REG_NUMBER_WIDTH-1:0] ins_rd,
    input  logic [EX_REG_NUMBER_WIDTH-1:0] ins_rs1,
    input  logic [EX_REG_NUMBER_WIDTH-1:0] ins_rs2,
    input  logic [DATA_WIDTH-1:0]          ins_imm,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [INS_WIDTH-1:0]           out_code,
    output logic                           out_err
);

    logic [INS_WIDTH-1:0] enc_code;
    logic                 enc_err;

    // Each slot stores {err, code}
    logic [INS_WIDTH:0]   mem_q [BUF_DEPTH];
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [1:0]           count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [INS_WIDTH-1:0] out_code_q, out_code_d;
    logic                 out_err_q, out_err_d;
    logic                 push, pop;

    ins_encoder_enc_core u_enc_core (
        .ins_type (ins_type),
        .ins_rd   (ins_rd),
        .ins_rs1  (ins_rs1),
        .ins_rs2  (ins_rs2),
        .ins_imm  (ins_imm),
        .code     (enc_code),
        .err      (enc_err)
    );

    // Handshake, pointer/count update and next head-of-queue output word
    always_comb begin
        in_ready = rdy_in && rst_in && ((count_q < 2'(BUF_DEPTH)) || out_ready);
        push     = in_valid && in_ready;
        pop      = rdy_in && out_valid_q && out_ready;
        head_d   = pop  ? ~head_q : head_q;
        tail_d   = push ? ~tail_q : tail_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        out_valid_d = (count_d != 2'd0);
        out_code_d  = out_code_q;
        out_err_d   = out_err_q;
        if (count_d != 2'd0) begin
            // The new head is either the word being written now or a stored one
            if (push && (tail_q == head_d))
                {out_err_d, out_code_d} = {enc_err, enc_code};
            else
                {out_err_d, out_code_d} = mem_q[head_d];
        end
    end

    // Control and output registers; stall leaves every _d equal to its _q
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_err_q   <= out_err_d;
        end
    end

    // Buffer storage written at the tail on every accepted request
    always_ff @(posedge clk_in) begin
        if (push)
            mem_q[tail_q] <= {enc_err, enc_code};
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/ins_encoder.md
Name: ins_encoder

Overview:
- Inverse of the RV32I instruction decoder. Accepts a decoded tuple (ins_type, rd, rs1, rs2, imm) and produces the 32-bit RV32I machine word.
- Used by the self-check/trace path. Decoded ops are re-encoded and compared against fetched words; the bench also uses it to generate instruction streams.
- Valid/ready on both sides. A 2-entry output buffer absorbs backpressure.

Parameters:
- BUF_DEPTH, 2, output buffer entries; fixed at 2; any other value is unsupported.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, synchronous active-low (reset when rst_in==0 at posedge clk_in)
- rdy_in  input  1  global ready; when 0, all state holds and in_ready=0
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&&in_ready&&rdy_in
- ins_type  input  `OPE_WIDTH  decoded op (`LUI..`AND, `EMPTY_INS)
- ins_rd  input  `EX_REG_NUMBER_WIDTH  destination; `REG_NUMBER = none
- ins_rs1  input  `EX_REG_NUMBER_WIDTH  source 1; `REG_NUMBER = none
- ins_rs2  input  `EX_REG_NUMBER_WIDTH  source 2; `REG_NUMBER = none
- ins_imm  input  `DATA_WIDTH  immediate in decoder form (sign-extended, or U-form with low 12 bits zero)
- out_valid  output  1  encoded word available
- out_ready  input  1  consumer accepts when out_valid&&out_ready&&rdy_in
- out_code  output  `INS_WIDTH  encoded instruction
- out_err  output  1  word is illegal; out_code=0 whenever out_err=1

Behaviour:
- Reset:
  - Buffer emptied; count=0.
  - out_valid=0, out_code=0, out_err=0.
  - in_ready=0 while reset is asserted, and 1 from the first cycle after.
- Latency:
  - A request accepted in cycle N is visible on out_code in cycle N+1 if the buffer was empty.
  - No combinational path from inputs to out_code.
- Buffer and handshake:
  - The buffer is a 2-entry FIFO with count 0..2.
  - in_ready = rdy_in && (count<2 || (count==2 && out_ready)).
  - Pop and push in the same cycle with count==2 is legal; count stays 2.
  - Full with no pop: in_ready=0.
  - Empty: out_valid=0 and out_code/out_err are held at their last value.
  - Head pointer wraps modulo 2.
- Stall: rdy_in=0 freezes count, pointers and outputs; no transfer occurs on either side.
- Reset mid-operation: buffered words are discarded, not emitted.
- Field mapping:
  - Register fields take bits [4:0] of the port. A `REG_NUMBER operand encodes as 0.
  - U-type (LUI 0x37, AUIPC 0x17): code[31:12]=imm[31:12].
  - J-type (JAL 0x6F): {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
  - JALR (0x67) and loads (0x03): I-type, imm[11:0]. Load funct3: LB 0, LH 1, LW 2, LBU 4, LHU 5.
  - Branches (0x63): {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],opcode}. funct3: BEQ 0, BNE 1, BLT 4, BGE 5, BLTU 6, BGEU 7.
  - Stores (0x23): {imm[11:5],rs2,rs1,f3,imm[4:0],opcode}. funct3: SB 0, SH 1, SW 2.
  - OP-IMM (0x13):
    - ADDI/SLTI/SLTIU/XORI/ORI/ANDI use I-type.
    - SLLI/SRLI/SRAI use shamt=imm[4:0] and funct7 0x00; SRAI uses funct7 0x20.
  - OP (0x33): funct7 0x20 for SUB and SRA, else 0x00.
- Illegal: `EMPTY_INS or an unlisted ins_type gives out_err=1 and out_code=0. The request is still accepted and emitted in order.

Optional Feature:
- ENC_RANGE_CHECK_EN defined: out_err=1 (out_code=0) if any of the following holds:
  - I/S imm is not a sign-extension of bit 11.
  - B imm is odd or not a 13-bit sign-extension.
  - J imm is odd or not a 21-bit sign-extension.
  - U imm[11:0]!=0.
  - Shift imm[31:5]!=0.
  - A required register operand equals `REG_NUMBER.
- Undefined: no range checks; bits out of range are silently truncated. The checking logic is absent from the RTL.

Decomposition:
- Opcode constants (OPC_LUI..OPC_OP), funct3 and funct7 constants go in the shared define.v with the existing `OPE_WIDTH/`INS_WIDTH macros.
- Sub-module enc_core: the pure combinational tuple-to-{code,err} function.
- ins_encoder holds only the FIFO and handshake.

Test Plan:
- ADDI rd=1 rs1=0 imm=5 -> out_code 0x00500093 one cycle after acceptance, out_err=0.
- LUI rd=5 imm=0x12345000 -> 0x123452B7; JAL rd=1 imm=8 -> 0x008000EF.
- BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; SW rs1=1 rs2=2 imm=12 -> 0x0020A623; SRAI rd=3 rs1=4 imm=7 -> 0x40725193.
- Backpressure, with out_ready=0:
  - 3 back-to-back requests -> 2 accepted, then in_ready=0.
  - out_ready=1 -> words emitted in order; the third is accepted in the same cycle as the first pop.
- `EMPTY_INS -> out_err=1, out_code=0. With ENC_RANGE_CHECK_EN, ADDI imm=0x800 -> out_err=1; without it -> 0x80000013 (rd=rs1=0).
- Reset and stall:
  - rst_in=0 with count=2 -> out_valid=0 next cycle, and the stale words never appear.
  - rdy_in=0 for 3 cycles with out_ready=1 -> no pop, outputs unchanged.
